// File: rtl/event_counter_display.sv
// Debounced push-button event counter with a multiplexed active-low 7-segment hex display.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero digit.
module event_counter_display #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int SATURATE        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  input  logic                  dir,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  overflow
);

  localparam int W    = 4 * DIGITS;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RF_W = $clog2(REFRESH_CYCLES + 1);
  localparam int IX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [W-1:0]      ALL_ONES = '1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0]   RF_LAST  = RF_W'(REFRESH_CYCLES - 1);
  localparam logic [IX_W-1:0]   IX_LAST  = IX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RST   = ~DIGITS'(1);

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            deb_q, deb_d, deb_prev_q, deb_prev_d, event_q, event_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [RF_W-1:0] rf_cnt_q, rf_cnt_d;
  logic [IX_W-1:0] idx_q, idx_d;
  logic [W-1:0]    count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]      nib;
  logic            at_max, at_min;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = 8'b00000011;
      4'h1:    hex_glyph = 8'b10011111;
      4'h2:    hex_glyph = 8'b00100101;
      4'h3:    hex_glyph = 8'b00001101;
      4'h4:    hex_glyph = 8'b10011001;
      4'h5:    hex_glyph = 8'b01001001;
      4'h6:    hex_glyph = 8'b01000001;
      4'h7:    hex_glyph = 8'b00011111;
      4'h8:    hex_glyph = 8'b00000001;
      4'h9:    hex_glyph = 8'b00001001;
      4'hA:    hex_glyph = 8'b00010001;
      4'hB:    hex_glyph = 8'b11000001;
      4'hC:    hex_glyph = 8'b01100011;
      4'hD:    hex_glyph = 8'b10000101;
      4'hE:    hex_glyph = 8'b01100001;
      default: hex_glyph = 8'b01110001;
    endcase
  endfunction

  always_comb begin
    sync1_d    = in;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    db_cnt_d   = '0;
    deb_prev_d = deb_q;
    event_d    = deb_q & ~deb_prev_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    rf_cnt_d   = rf_cnt_q + RF_W'(1);
    idx_d      = idx_q;
    at_max     = (count_q == ALL_ONES);
    at_min     = (count_q == '0);

    // Stability run only advances while the synchronized input disagrees with the accepted level.
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    if (clear) begin
      count_d = '0;
    end else if (event_q) begin
      if (dir) begin
        overflow_d = at_max;
        if (!(SATURATE != 0 && at_max)) count_d = count_q + W'(1);
      end else begin
        overflow_d = at_min;
        if (!(SATURATE != 0 && at_min)) count_d = count_q - W'(1);
      end
    end

    if (rf_cnt_q == RF_LAST) begin
      rf_cnt_d = '0;
      idx_d    = (idx_q == IX_LAST) ? '0 : idx_q + IX_W'(1);
    end

    // Display registers track the next count/index so seg and an always agree with count.
    nib   = 4'(count_d >> (4 * idx_d));
    seg_d = hex_glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d != '0 && (count_d >> (4 * idx_d)) == '0) seg_d = 8'hFF;
`else
`endif
    an_d = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      event_q    <= 1'b0;
      db_cnt_q   <= '0;
      rf_cnt_q   <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      seg_q      <= 8'b00000011;
      an_q       <= AN_RST;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      event_q    <= event_d;
      db_cnt_q   <= db_cnt_d;
      rf_cnt_q   <= rf_cnt_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_event_counter_display.sv
// Bench for event_counter_display: a wrapping and a saturating instance share stimulus and are
// compared every cycle against an event-timeline reference model.
module tb_event_counter_display;

  localparam int DIG  = 2;
  localparam int DB   = 4;
  localparam int RF   = 3;
  localparam int MAXV = (1 << (4 * DIG)) - 1;

  logic clk = 1'b0;
  logic reset, in_r, dir, clear;
  logic [4*DIG-1:0] count_w, count_s;
  logic [7:0]       seg_w, seg_s;
  logic [DIG-1:0]   an_w, an_s;
  logic             ovf_w, ovf_s;

  always #5 clk = ~clk;

  event_counter_display #(.DIGITS(DIG), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .in(in_r), .dir(dir), .clear(clear),
    .count(count_w), .seg(seg_w), .an(an_w), .overflow(ovf_w));

  event_counter_display #(.DIGITS(DIG), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .in(in_r), .dir(dir), .clear(clear),
    .count(count_s), .seg(seg_s), .an(an_s), .overflow(ovf_s));

  int total = 0;
  int bad   = 0;

  // Reference state: raw input history, accepted level, run length, scheduled event edges.
  bit hist[$];
  int pend[$];
  int n, run, mcw, mcs;
  bit lvl, mow, mos;

  function automatic logic [7:0] glyph(input int v);
    case (v & 15)
      0:  glyph = 8'b00000011;  1:  glyph = 8'b10011111;
      2:  glyph = 8'b00100101;  3:  glyph = 8'b00001101;
      4:  glyph = 8'b10011001;  5:  glyph = 8'b01001001;
      6:  glyph = 8'b01000001;  7:  glyph = 8'b00011111;
      8:  glyph = 8'b00000001;  9:  glyph = 8'b00001001;
      10: glyph = 8'b00010001;  11: glyph = 8'b11000001;
      12: glyph = 8'b01100011;  13: glyph = 8'b10000101;
      14: glyph = 8'b01100001;  default: glyph = 8'b01110001;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int cnt, input int idx);
    int upper;
    upper = cnt >> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && upper == 0) return 8'hFF;
`endif
    return glyph(upper);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit s, ev;
    if (!reset) begin
      hist.delete(); pend.delete();
      n = 0; run = 0; lvl = 0; mcw = 0; mcs = 0; mow = 0; mos = 0;
    end else begin
      hist.push_back(in_r);
      if (hist.size() > 3) void'(hist.pop_front());
      s  = (hist.size() == 3) ? hist[0] : 1'b0;
      ev = (pend.size() > 0 && pend[0] == n);
      if (ev) void'(pend.pop_front());
      mow = 0; mos = 0;
      if (clear) begin
        mcw = 0; mcs = 0;
      end else if (ev) begin
        if (dir) begin
          mow = (mcw == MAXV); mcw = (mcw + 1) % (MAXV + 1);
          mos = (mcs == MAXV); if (mcs < MAXV) mcs++;
        end else begin
          mow = (mcw == 0); mcw = (mcw + MAXV) % (MAXV + 1);
          mos = (mcs == 0); if (mcs > 0) mcs--;
        end
      end
      // A rising acceptance reaches the count two edges later.
      if (s != lvl) begin
        run++;
        if (run == DB) begin
          lvl = s; run = 0;
          if (s) pend.push_back(n + 2);
        end
      end else begin
        run = 0;
      end
      n++;
    end
  endtask

  task automatic step();
    int idx;
    logic [DIG-1:0] ea;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idx = (n / RF) % DIG;
    ea = '1;
    ea[idx] = 1'b0;
    check("count_wrap", count_w, mcw);
    check("count_sat",  count_s, mcs);
    check("ovf_wrap",   ovf_w,   mow);
    check("ovf_sat",    ovf_s,   mos);
    check("an_wrap",    an_w,    ea);
    check("an_sat",     an_s,    ea);
    check("seg_wrap",   seg_w,   exp_seg(mcw, idx));
    check("seg_sat",    seg_s,   exp_seg(mcs, idx));
  endtask

  task automatic press(input logic d);
    dir  = d;
    in_r = 1'b1;
    repeat (DB + 2) step();
    in_r = 1'b0;
    repeat (DB + 2) step();
  endtask

  initial begin
    bit hit;
    reset = 1'b0; in_r = 1'b0; dir = 1'b1; clear = 1'b0;
    repeat (2) step();
    reset = 1'b1;

    // Clean press held 20 cycles: one event, 7 edges after the rise.
    in_r = 1'b1;
    repeat (20) step();
    in_r = 1'b0;
    repeat (10) step();
    check("single_press", count_w, 1);

    // Bounce every 2 cycles never survives the stability window.
    for (int i = 0; i < 20; i++) begin
      in_r = ~in_r;
      repeat (2) step();
    end
    in_r = 1'b0;
    repeat (8) step();
    check("bounce_ignored", count_w, 1);

    press(1'b0);
    press(1'b0);
    check("wrap_down", count_w, MAXV);
    check("sat_down",  count_s, 0);

    for (int i = 0; i < 256; i++) press(1'b1);
    check("wrap_full_cycle", count_w, MAXV);
    check("sat_up_hold",     count_s, MAXV);

    // Clear landing on the same edge as an up event at all-ones.
    dir = 1'b1; in_r = 1'b1; hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      hit = (pend.size() > 0 && pend[0] == n);
      if (!hit) step();
    end
    if (!hit) begin
      total++; bad++;
      $error("FAIL clr_evt_timeout observed=none expected=event");
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_evt_count", count_w, 0);
    check("clr_evt_ovf",   ovf_w,   0);
    in_r = 1'b0;
    repeat (8) step();

    // Reset mid-debounce, input still high afterwards: exactly one event.
    in_r = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (14) step();
    check("post_reset_evt", count_w, 1);
    in_r = 1'b0;
    repeat (8) step();

    for (int i = 0; i < 80; i++) begin
      dir   = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 9) == 0);
      in_r  = 1'b1;
      repeat ($urandom_range(1, 8)) step();
      clear = 1'b0;
      in_r  = 1'b0;
      repeat ($urandom_range(1, 8)) step();
    end
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
